cpu_icache_burst: RTL and testbench

CPU_ICACHE_BURST -- requirements
Module: cpu_icache_burst

---
 rtl/cpu_icache_burst.sv | 232 +++++++++++++++++++++++
 tb/tb_cpu_icache_burst.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_icache_burst.sv
// ---------------------------------------------------------------------------
// cpu_icache_burst
//   Direct-mapped instruction cache. Lines are refilled whole from a
//   single-word read bus, one word per bus-ready cycle.
//
//   Ports:
//     i_clock        sole clock, rising edge
//     i_reset        asynchronous active-low reset
//     i_input_pc     fetch address (word aligned)
//     i_stall        pipeline stall
//     o_ready        fetch-complete strobe
//     o_rdata        instruction word, valid only with o_ready (0 otherwise)
//     i_flush        invalidate-all request
//     o_flush_busy   high while the valid array is being cleared
//     o_bus_request  read request to the backing bus
//     i_bus_ready    bus word accepted / returned this cycle
//     o_bus_address  bus word address
//     i_bus_rdata    bus read data
//     o_hit, o_miss  saturating lookup counters
// ---------------------------------------------------------------------------
module cpu_icache_burst #(
  parameter int SIZE      = 8,
  parameter int LINE_LOG2 = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_input_pc,
  input  logic        i_stall,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  input  logic        i_flush,
  output logic        o_flush_busy,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_hit,
  output logic [31:0] o_miss
);

  localparam int LINES  = 1 << SIZE;
  localparam int WORDS  = 1 << (SIZE + LINE_LOG2);
  localparam int IDX_LO = LINE_LOG2 + 2;
  localparam int TAG_LO = SIZE + LINE_LOG2 + 2;
  localparam int TAG_W  = 32 - TAG_LO;
  localparam int RW     = SIZE + LINE_LOG2;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_FILL
  } state_t;

  state_t               state_q, state_d;
  logic [SIZE-1:0]      init_idx_q, init_idx_d;
  logic [31:0]          lookup_pc_q, lookup_pc_d;
  logic [31:IDX_LO]     fill_line_q, fill_line_d;
  logic [LINE_LOG2-1:0] fill_off_q, fill_off_d;
  logic [LINE_LOG2-1:0] fill_cnt_q, fill_cnt_d;
  logic [31:0]          fill_word_q, fill_word_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [31:0]          hit_q, hit_d;
  logic [31:0]          miss_q, miss_d;

  // Tag/valid and data arrays, one-cycle synchronous read
  logic                 valid_mem [LINES];
  logic [TAG_W-1:0]     tag_mem   [LINES];
  logic [31:0]          data_mem  [WORDS];
  logic                 valid_rd_q;
  logic [TAG_W-1:0]     tag_rd_q;
  logic [31:0]          data_rd_q;

  logic [RW-1:0]        rd_widx;
  logic                 line_we;
  logic [SIZE-1:0]      line_idx;
  logic                 line_valid;
  logic                 data_we;
  logic [RW-1:0]        data_widx;

  logic                 ready;
  logic [31:0]          rdata;
  logic                 lookup_hit;
  logic [31:0]          pc_next;

  assign lookup_hit = valid_rd_q && (tag_rd_q == lookup_pc_q[31:TAG_LO]);
  assign pc_next    = lookup_pc_q + 32'd4;  // wraps 0xFFFF_FFFC -> 0

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    lookup_pc_d  = lookup_pc_q;
    fill_line_d  = fill_line_q;
    fill_off_d   = fill_off_q;
    fill_cnt_d   = fill_cnt_q;
    fill_word_d  = fill_word_q;
    flush_pend_d = flush_pend_q;
    hit_d        = hit_q;
    miss_d       = miss_q;

    rd_widx      = lookup_pc_q[TAG_LO-1:2];
    line_we      = 1'b0;
    line_idx     = fill_line_q[TAG_LO-1:IDX_LO];
    line_valid   = 1'b0;
    data_we      = 1'b0;
    data_widx    = {fill_line_q[TAG_LO-1:IDX_LO], fill_cnt_q};
    ready        = 1'b0;
    rdata        = '0;

    case (state_q)
      S_INIT: begin
        line_we      = 1'b1;
        line_idx     = init_idx_q;
        line_valid   = 1'b0;
        flush_pend_d = 1'b0;
        if (i_flush) begin
          init_idx_d = '0;
        end else if (&init_idx_q) begin
          init_idx_d = '0;
          state_d    = S_IDLE;
        end else begin
          init_idx_d = init_idx_q + SIZE'(1);
        end
      end

      S_IDLE: begin
        rd_widx     = i_input_pc[TAG_LO-1:2];
        lookup_pc_d = i_input_pc;
        if (i_flush) begin
          init_idx_d = '0;
          state_d    = S_INIT;
        end else if (!i_stall) begin
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (i_flush) begin
          init_idx_d = '0;
          state_d    = S_INIT;
        end else if (i_stall || (i_input_pc != lookup_pc_q)) begin
          // Fetch abandoned; IDLE re-presents whatever the pipeline asks for next
          state_d = S_IDLE;
        end else if (lookup_hit) begin
          ready       = 1'b1;
          rdata       = data_rd_q;
          hit_d       = (&hit_q) ? hit_q : hit_q + 32'd1;
          rd_widx     = pc_next[TAG_LO-1:2];
          lookup_pc_d = pc_next;
        end else begin
          miss_d      = (&miss_q) ? miss_q : miss_q + 32'd1;
          fill_line_d = lookup_pc_q[31:IDX_LO];
          fill_off_d  = lookup_pc_q[IDX_LO-1:2];
          fill_cnt_d  = '0;
          state_d     = S_FILL;
        end
      end

      S_FILL: begin
        if (i_flush) flush_pend_d = 1'b1;
        if (i_bus_ready) begin
          data_we    = 1'b1;
          fill_cnt_d = fill_cnt_q + LINE_LOG2'(1);
          if (fill_cnt_q == fill_off_q) fill_word_d = i_bus_rdata;
          if (&fill_cnt_q) begin
            line_we    = 1'b1;
            line_valid = 1'b1;
            ready      = 1'b1;
            // Requested word may be the one arriving right now
            rdata      = (&fill_off_q) ? i_bus_rdata : fill_word_q;
            if (flush_pend_q || i_flush) begin
              flush_pend_d = 1'b0;
              init_idx_d   = '0;
              state_d      = S_INIT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= S_INIT;
      init_idx_q   <= '0;
      lookup_pc_q  <= '0;
      fill_line_q  <= '0;
      fill_off_q   <= '0;
      fill_cnt_q   <= '0;
      fill_word_q  <= '0;
      flush_pend_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      lookup_pc_q  <= lookup_pc_d;
      fill_line_q  <= fill_line_d;
      fill_off_q   <= fill_off_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_word_q  <= fill_word_d;
      flush_pend_q <= flush_pend_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  // Storage arrays: no reset, contents qualified by the valid array
  always_ff @(posedge i_clock) begin
    if (line_we) begin
      valid_mem[line_idx] <= line_valid;
      tag_mem[line_idx]   <= fill_line_q[31:TAG_LO];
    end
    if (data_we) data_mem[data_widx] <= i_bus_rdata;
    valid_rd_q <= valid_mem[rd_widx[RW-1:LINE_LOG2]];
    tag_rd_q   <= tag_mem[rd_widx[RW-1:LINE_LOG2]];
    data_rd_q  <= data_mem[rd_widx];
  end

  assign o_ready       = ready;
  assign o_rdata       = rdata;
  assign o_flush_busy  = (state_q == S_INIT);
  assign o_bus_request = (state_q == S_FILL);
  assign o_bus_address = (state_q == S_FILL) ? {fill_line_q, fill_cnt_q, 2'b00} : '0;
  assign o_hit         = hit_q;
  assign o_miss        = miss_q;

endmodule

// File: tb/tb_cpu_icache_burst.sv
// ---------------------------------------------------------------------------
// tb_cpu_icache_burst
//   Directed bench for cpu_icache_burst with SIZE=4, LINE_LOG2=2.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_cpu_icache_burst;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_input_pc;
  logic        i_stall;
  logic        o_ready;
  logic [31:0] o_rdata;
  logic        i_flush;
  logic        o_flush_busy;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;
  logic [31:0] o_hit;
  logic [31:0] o_miss;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] addrs[$];

  always #5 i_clock = ~i_clock;

  // Backing memory: tag 1 -> 0xA0.., tag 5 -> 0xB0.., anything else 0xC0..
  function automatic logic [31:0] bus_word(input logic [31:0] a);
    case (a[31:8])
      24'h000001: return 32'hA0 + 32'(a[3:2]);
      24'h000005: return 32'hB0 + 32'(a[3:2]);
      default:    return 32'hC0 + 32'(a[3:2]);
    endcase
  endfunction

  assign i_bus_rdata = bus_word(o_bus_address);

  cpu_icache_burst #(.SIZE(4), .LINE_LOG2(2)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_input_pc    (i_input_pc),
    .i_stall       (i_stall),
    .o_ready       (o_ready),
    .o_rdata       (o_rdata),
    .i_flush       (i_flush),
    .o_flush_busy  (o_flush_busy),
    .o_bus_request (o_bus_request),
    .i_bus_ready   (i_bus_ready),
    .o_bus_address (o_bus_address),
    .i_bus_rdata   (i_bus_rdata),
    .o_hit         (o_hit),
    .o_miss        (o_miss)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge i_clock);
    #1;
  endtask

  function automatic logic [31:0] addr_at(input int i);
    return (i < addrs.size()) ? addrs[i] : 32'hDEAD_BEEF;
  endfunction

  // Count falling edges with o_flush_busy high (bounded) and any o_ready seen
  task automatic wait_init(output int n, output int nready);
    n = 0;
    nready = 0;
    @(negedge i_clock);
    while (o_flush_busy && n < 100) begin
      if (o_ready) nready++;
      n++;
      @(negedge i_clock);
    end
  endtask

  // Issue one fetch, wait (bounded) for o_ready, record bus addresses,
  // then stall and watch for stray extra o_ready pulses
  task automatic fetch(input logic [31:0] pc, output logic [31:0] data,
                       output int nready, output int nbus);
    nready = 0;
    nbus   = 0;
    data   = '0;
    addrs.delete();
    next_cycle();
    i_input_pc = pc;
    i_stall    = 1'b0;
    for (int c = 0; c < 40 && nready == 0; c++) begin
      @(negedge i_clock);
      if (o_bus_request && i_bus_ready) begin
        addrs.push_back(o_bus_address);
        nbus++;
      end
      if (o_ready) begin
        nready++;
        data = o_rdata;
      end else begin
        next_cycle();
      end
    end
    next_cycle();
    i_stall = 1'b1;
    repeat (3) begin
      @(negedge i_clock);
      if (o_ready) nready++;
      next_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          nr, nb, n, ir;

    i_reset     = 1'b0;
    i_input_pc  = '0;
    i_stall     = 1'b1;
    i_flush     = 1'b0;
    i_bus_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge i_clock);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_busreq", 32'(o_bus_request), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_hit", o_hit, 32'd0);
    check("rst_miss", o_miss, 32'd0);
    check("rst_busy", 32'(o_flush_busy), 32'd1);

    // Release: 16 init cycles, no o_ready
    next_cycle();
    i_reset = 1'b1;
    wait_init(n, ir);
    check("init_cycles", 32'(n), 32'd16);
    check("init_ready", 32'(ir), 32'd0);

    // Cold fetch of 0x104: whole line from word 0, requested word A1
    fetch(32'h104, d, nr, nb);
    check("cold_nready", 32'(nr), 32'd1);
    check("cold_data", d, 32'hA1);
    check("cold_nbus", 32'(nb), 32'd4);
    check("cold_addr0", addr_at(0), 32'h100);
    check("cold_addr1", addr_at(1), 32'h104);
    check("cold_addr2", addr_at(2), 32'h108);
    check("cold_addr3", addr_at(3), 32'h10C);
    check("cold_miss", o_miss, 32'd1);
    check("cold_hit", o_hit, 32'd0);

    // Back-to-back hits across the line
    next_cycle();
    i_input_pc = 32'h100;
    i_stall    = 1'b0;
    @(negedge i_clock);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      i_input_pc = 32'h100 + 32'(4 * i);
      @(negedge i_clock);
      check("b2b_ready", 32'(o_ready), 32'd1);
      check("b2b_data", o_rdata, 32'hA0 + 32'(i));
      check("b2b_busreq", 32'(o_bus_request), 32'd0);
    end
    next_cycle();
    i_stall = 1'b1;
    @(negedge i_clock);
    check("b2b_stall_ready", 32'(o_ready), 32'd0);
    check("b2b_hit", o_hit, 32'd4);
    check("b2b_miss", o_miss, 32'd1);

    // Conflict: 0x500 evicts 0x100, then 0x100 misses again
    fetch(32'h500, d, nr, nb);
    check("conf1_data", d, 32'hB0);
    check("conf1_nbus", 32'(nb), 32'd4);
    fetch(32'h100, d, nr, nb);
    check("conf2_data", d, 32'hA0);
    check("conf2_nready", 32'(nr), 32'd1);
    check("conf_miss", o_miss, 32'd3);
    check("conf_hit", o_hit, 32'd4);

    // Flush pulse at word 1 of a fill (with stall raised too)
    next_cycle();
    i_input_pc = 32'h504;
    i_stall    = 1'b0;
    @(negedge i_clock);                 // IDLE
    next_cycle();
    @(negedge i_clock);                 // LOOKUP miss
    next_cycle();
    @(negedge i_clock);                 // FILL word 0
    check("fl_addr0", o_bus_address, 32'h500);
    next_cycle();
    i_flush = 1'b1;
    i_stall = 1'b1;
    @(negedge i_clock);                 // FILL word 1
    check("fl_busreq1", 32'(o_bus_request), 32'd1);
    check("fl_busy_fill", 32'(o_flush_busy), 32'd0);
    next_cycle();
    i_flush = 1'b0;
    @(negedge i_clock);                 // FILL word 2
    check("fl_ready_w2", 32'(o_ready), 32'd0);
    next_cycle();
    @(negedge i_clock);                 // FILL word 3
    check("fl_ready", 32'(o_ready), 32'd1);
    check("fl_data", o_rdata, 32'hB1);
    next_cycle();
    wait_init(n, ir);
    check("fl_init_cycles", 32'(n), 32'd16);
    check("fl_init_ready", 32'(ir), 32'd0);
    fetch(32'h100, d, nr, nb);
    check("fl_refetch_nbus", 32'(nb), 32'd4);
    check("fl_refetch_data", d, 32'hA0);
    check("fl_miss", o_miss, 32'd5);

    // Reset asserted at word 2 of a fill
    next_cycle();
    i_input_pc = 32'h200;
    i_stall    = 1'b0;
    @(negedge i_clock);                 // IDLE
    next_cycle();
    @(negedge i_clock);                 // LOOKUP miss
    next_cycle();
    @(negedge i_clock);                 // word 0
    next_cycle();
    @(negedge i_clock);                 // word 1
    next_cycle();
    @(negedge i_clock);                 // word 2
    check("rf_busreq_before", 32'(o_bus_request), 32'd1);
    check("rf_addr2", o_bus_address, 32'h208);
    #1;
    i_reset = 1'b0;
    #1;
    check("rf_busreq_drop", 32'(o_bus_request), 32'd0);
    check("rf_miss_clr", o_miss, 32'd0);
    check("rf_hit_clr", o_hit, 32'd0);
    check("rf_busy", 32'(o_flush_busy), 32'd1);
    next_cycle();
    i_reset = 1'b1;
    i_stall = 1'b1;
    wait_init(n, ir);
    check("rf_init_cycles", 32'(n), 32'd16);
    fetch(32'h200, d, nr, nb);
    check("rf_refetch_nbus", 32'(nb), 32'd4);
    check("rf_refetch_data", d, 32'hC0);
    check("rf_refetch_miss", o_miss, 32'd1);
    check("rf_refetch_hit", o_hit, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
